// File: rtl/cen_frac_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
// The config struct is sized by DEF_ACC_W; the generator's ACC_W parameter
// must stay equal to it so that ports and stored config line up bit for bit.
package cen_frac_pkg;

  localparam int DEF_ACC_W       = 24;
  localparam int DEF_LOCK_CYCLES = 16;

  typedef struct packed {
    logic [DEF_ACC_W-1:0] num;
    logic [DEF_ACC_W-1:0] den;
    logic [DEF_ACC_W-1:0] phase;
  } cen_cfg_t;

  // A channel can only run when the modulus is non-zero, the increment does
  // not exceed it and the preload already lies inside the modulus range.
  function automatic logic cfg_valid(input cen_cfg_t c);
    return (c.den != '0) && (c.num <= c.den) && (c.phase < c.den);
  endfunction

endpackage

// File: rtl/cen_frac_ch.sv
// One fractional enable channel: config registers, phase accumulator,
// registered enable pulse and illegal-config flag.
module cen_frac_ch
  import cen_frac_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     wr,
  input  cen_cfg_t wr_cfg,
  input  logic     sync,
  output logic     cen,
  output logic     err
);

  cen_cfg_t         cfg_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             cen_reg;
  logic             err_reg;

  logic [ACC_W:0]   sum;
  logic             hit;
  logic [ACC_W-1:0] acc_wrap;
  logic             run;

  // Sum is one bit wider so acc + num can never wrap before the compare.
  assign sum = {1'b0, acc_reg} + {1'b0, cfg_reg.num};
  assign hit = (sum >= {1'b0, cfg_reg.den});
  // acc + num - den rewritten as acc - (den - num): num <= den whenever the
  // channel runs, so neither subtraction can underflow.
  assign acc_wrap = acc_reg - (cfg_reg.den - cfg_reg.num);
  // The all-zero reset config is invalid yet not flagged: it is simply idle.
  assign run = cfg_valid(cfg_reg);

  // Config load / phase reload / accumulate; a write wins over a sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_reg <= '0;
      acc_reg <= '0;
      cen_reg <= 1'b0;
      err_reg <= 1'b0;
    end else if (wr) begin
      cfg_reg <= wr_cfg;
      acc_reg <= wr_cfg.phase;
      cen_reg <= 1'b0;
      err_reg <= !cfg_valid(wr_cfg);
    end else if (sync) begin
      acc_reg <= cfg_reg.phase;
      cen_reg <= 1'b0;
    end else if (run) begin
      acc_reg <= hit ? acc_wrap : sum[ACC_W-1:0];
      cen_reg <= hit;
    end else begin
      cen_reg <= 1'b0;
    end
  end

  assign cen = cen_reg;
  assign err = err_reg;

endmodule

// File: rtl/cen_frac_gen.sv
// Multi-channel fractional clock-enable generator: per-channel write decode,
// sync fan-out and a lock counter that reports when all channels have settled.
module cen_frac_gen
  import cen_frac_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]                         cfg_num,
  input  logic [ACC_W-1:0]                         cfg_den,
  input  logic [ACC_W-1:0]                         cfg_phase,
  input  logic                                     sync_all,
  output logic [NUM_CH-1:0]                        cen,
  output logic [NUM_CH-1:0]                        ch_err,
  output logic                                     locked
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  cen_cfg_t          wr_cfg;
  logic [NUM_CH-1:0] wr_sel;
  logic              clear;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic              locked_reg;

  assign wr_cfg = '{num: cfg_num, den: cfg_den, phase: cfg_phase};

  // An out-of-range channel index matches no channel, so the write is dropped.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign wr_sel[gi] = cfg_we && (cfg_ch == CH_W'(gi));

      cen_frac_ch #(
        .ACC_W (ACC_W)
      ) u_ch (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr     (wr_sel[gi]),
        .wr_cfg (wr_cfg),
        .sync   (sync_all),
        .cen    (cen[gi]),
        .err    (ch_err[gi])
      );
    end
  endgenerate

  // Any write attempt (even a dropped one) or a sync restarts the settle time.
  assign clear = cfg_we | sync_all;

  // Settle counter: restart on clear, otherwise count up and saturate.
  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (cnt_reg != CNT_W'(LOCK_CYCLES)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Count register and lock flag; lock needs full settle time and no bad channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      locked_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      locked_reg <= !clear && (cnt_next == CNT_W'(LOCK_CYCLES)) && (ch_err == '0);
    end
  end

  assign locked = locked_reg;

endmodule

// File: tb/tb_cen_frac_gen.sv
// Directed bench for cen_frac_gen (NUM_CH=3, ACC_W=24, LOCK_CYCLES=16).
module tb_cen_frac_gen;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [23:0] cfg_num;
  logic [23:0] cfg_den;
  logic [23:0] cfg_phase;
  logic        sync_all;
  logic [2:0]  cen;
  logic [2:0]  ch_err;
  logic        locked;

  int n_vec  = 0;
  int n_fail = 0;

  cen_frac_gen #(
    .NUM_CH      (3),
    .ACC_W       (24),
    .LOCK_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_num   (cfg_num),
    .cfg_den   (cfg_den),
    .cfg_phase (cfg_phase),
    .sync_all  (sync_all),
    .cen       (cen),
    .ch_err    (ch_err),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle config write; returns at the negedge after the write edge.
  task automatic cfg_write(input int ch, input int num, input int den, input int phase);
    cfg_ch    = 2'(ch);
    cfg_num   = 24'(num);
    cfg_den   = 24'(den);
    cfg_phase = 24'(phase);
    cfg_we    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_we    = 1'b0;
    $display("write ch%0d num=%0d den=%0d phase=%0d", ch, num, den, phase);
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cfg_we = 1'b0; sync_all = 1'b0;
    cfg_ch = '0; cfg_num = '0; cfg_den = '0; cfg_phase = '0;
    #12;
    n_vec++;
    if ({cen, ch_err, locked} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cen=%b err=%b locked=%b, want all 0", cen, ch_err, locked);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_vec++;
      if (cen !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d: got cen=%b, want 000", k, cen);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_div16;
    cfg_write(0, 1, 16, 0);
    for (int k = 1; k <= 48; k++) begin
      step();
      n_vec++;
      if (cen[0] !== (k % 16 == 0)) begin
        n_fail++;
        $display("FAIL div16_cen k=%0d: got %b, want %b", k, cen[0], (k % 16 == 0));
      end
      if (k == 15 || k == 16) begin
        n_vec++;
        if (locked !== (k == 16)) begin
          n_fail++;
          $display("FAIL div16_locked k=%0d: got %b, want %b", k, locked, (k == 16));
        end
      end
    end
    $display("test_div16 done");
  endtask

  task automatic test_ntsc;
    int w0, w1, last, first, bad_iv;
    w0 = 0; w1 = 0; last = 0; first = 0; bad_iv = 0;
    cfg_write(1, 63, 880, 0);
    for (int k = 1; k <= 1760; k++) begin
      step();
      if (cen[1]) begin
        if (k <= 880) w0++; else w1++;
        if (last == 0) first = k;
        else if ((k - last) != 13 && (k - last) != 14) bad_iv++;
        last = k;
      end
    end
    n_vec++;
    if (first !== 14) begin
      n_fail++;
      $display("FAIL ntsc_first: got cycle %0d, want 14", first);
    end
    n_vec++;
    if (w0 !== 63) begin
      n_fail++;
      $display("FAIL ntsc_window0: got %0d pulses, want 63", w0);
    end
    n_vec++;
    if (w1 !== 63) begin
      n_fail++;
      $display("FAIL ntsc_window1: got %0d pulses, want 63", w1);
    end
    n_vec++;
    if (bad_iv !== 0) begin
      n_fail++;
      $display("FAIL ntsc_interval: got %0d intervals outside 13/14, want 0", bad_iv);
    end
    $display("test_ntsc done: %0d/%0d pulses", w0, w1);
  endtask

  task automatic test_phase_align;
    cfg_write(0, 1, 4, 0);
    cfg_write(2, 1, 4, 2);
    sync_all = 1'b1;
    step();
    sync_all = 1'b0;
    n_vec++;
    if ({cen[2], cen[0], locked} !== 3'b000) begin
      n_fail++;
      $display("FAIL align_sync_cycle: got cen2=%b cen0=%b locked=%b, want 000", cen[2], cen[0], locked);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      n_vec++;
      if (cen[0] !== (k % 4 == 0) || cen[2] !== (k % 4 == 2)) begin
        n_fail++;
        $display("FAIL align k=%0d: got cen0=%b cen2=%b, want %b %b",
                 k, cen[0], cen[2], (k % 4 == 0), (k % 4 == 2));
      end
    end
    $display("test_phase_align done");
  endtask

  task automatic test_bad_cfg;
    cfg_write(2, 5, 4, 0);
    n_vec++;
    if (ch_err !== 3'b100) begin
      n_fail++;
      $display("FAIL bad_num_err: got %b, want 100", ch_err);
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      n_vec++;
      if (cen[2] !== 1'b0 || locked !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_quiet k=%0d: got cen2=%b locked=%b, want 0 0", k, cen[2], locked);
      end
    end
    cfg_write(2, 5, 0, 0);
    n_vec++;
    if (ch_err[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_den0_err: got %b, want 1", ch_err[2]);
    end
    cfg_write(2, 1, 4, 4);
    n_vec++;
    if (ch_err[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_phase_err: got %b, want 1", ch_err[2]);
    end
    cfg_write(2, 1, 4, 0);
    n_vec++;
    if (ch_err !== 3'b000) begin
      n_fail++;
      $display("FAIL good_clears_err: got %b, want 000", ch_err);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k >= 15) begin
        n_vec++;
        if (locked !== (k == 16)) begin
          n_fail++;
          $display("FAIL relock k=%0d: got %b, want %b", k, locked, (k == 16));
        end
      end
    end
    $display("test_bad_cfg done");
  endtask

  task automatic test_boundaries;
    cfg_write(0, 4, 4, 0);
    n_vec++;
    if (cen[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL eq_write_cycle: got %b, want 0", cen[0]);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      n_vec++;
      if (cen[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL eq_every k=%0d: got %b, want 1", k, cen[0]);
      end
    end
    n_vec++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_oor_locked: got %b, want 1", locked);
    end
    cfg_write(3, 1, 2, 0);
    n_vec++;
    if (locked !== 1'b0 || ch_err !== 3'b000 || cen[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_write: got locked=%b err=%b cen0=%b, want 0 000 1", locked, ch_err, cen[0]);
    end
    $display("test_boundaries done");
  endtask

  task automatic test_sync_with_cfg;
    cfg_write(0, 1, 4, 0);
    cfg_write(2, 1, 4, 2);
    cfg_ch = 2'd0; cfg_num = 24'd1; cfg_den = 24'd4; cfg_phase = 24'd3;
    cfg_we = 1'b1; sync_all = 1'b1;
    step();
    cfg_we = 1'b0; sync_all = 1'b0;
    n_vec++;
    if (cen !== 3'b000 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_cfg_cycle: got cen=%b locked=%b, want 000 0", cen, locked);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      n_vec++;
      if (cen[0] !== (k % 4 == 1) || cen[2] !== (k % 4 == 2) || cen[1] !== (k == 14)) begin
        n_fail++;
        $display("FAIL sync_cfg k=%0d: got cen=%b, want %b%b%b",
                 k, cen, (k % 4 == 2), (k == 14), (k % 4 == 1));
      end
      if (k >= 15) begin
        n_vec++;
        if (locked !== (k == 16)) begin
          n_fail++;
          $display("FAIL sync_cfg_locked k=%0d: got %b, want %b", k, locked, (k == 16));
        end
      end
    end
    $display("test_sync_with_cfg done");
  endtask

  task automatic test_reset_mid;
    int bad;
    cfg_write(0, 4, 4, 0);
    for (int k = 1; k <= 16; k++) step();
    @(posedge clk);
    #2;
    n_vec++;
    if (cen[0] !== 1'b1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got cen0=%b locked=%b, want 1 1", cen[0], locked);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (cen !== 3'b000 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_a: got cen=%b locked=%b, want 000 0", cen, locked);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cfg_write(0, 4, 4, 0);
    cfg_write(2, 5, 4, 0);
    n_vec++;
    if (ch_err[2] !== 1'b1 || cen[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_b: got err2=%b cen0=%b, want 1 1", ch_err[2], cen[0]);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (cen !== 3'b000 || ch_err !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset_b: got cen=%b err=%b, want 000 000", cen, ch_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (cen !== 3'b000 || ch_err !== 3'b000) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %0d active cycles, want 0", bad);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_div16();
    test_ntsc();
    test_phase_align();
    test_bad_cfg();
    test_boundaries();
    test_sync_with_cfg();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
